// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter
// Time-shares a single external param_comparator among NUM_REQ requesters.
// A round-robin arbiter picks one valid request in IDLE, the winning operand
// pair is registered and presented to the comparator for one COMPARE cycle,
// and the sampled Equal/Greater/Less flags are returned as a tagged response
// that waits in RESPOND until the consumer accepts it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is one-hot (or zero) and only ever high in IDLE,
// so at most one request is accepted per edge. rsp_valid stays high with
// rsp_id/rsp_* stable until rsp_ready is seen high at an edge.
//
// Optional build macro: CMP_RESULT_CHECK_EN. When defined, the comparator
// result is cross-checked against a local unsigned compare during COMPARE and
// any disagreement (or a non-one-hot result) sets the sticky cmp_err flag.
// When undefined, cmp_err is tied low and no check logic exists.
//
// dbg_state exposes the FSM state (0=IDLE, 1=COMPARE, 2=RESPOND) for
// observation; it carries no functional meaning for the requesters.

module cmp_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         cmp_a,
  output logic [WIDTH-1:0]         cmp_b,
  input  logic                     cmp_equal,
  input  logic                     cmp_greater,
  input  logic                     cmp_less,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_equal,
  output logic                     rsp_greater,
  output logic                     rsp_less,
  output logic                     cmp_err,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // Arbitration results (combinational)
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W:0]    cand_sum;
  logic [ID_W-1:0]  cand;
  logic             cand_valid;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [ID_W-1:0]  next_ptr;

  // Round-robin search: first valid requester at or above rr_ptr, with wrap
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    cand_sum   = '0;
    cand       = '0;
    cand_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      end
      cand = cand_sum[ID_W-1:0];
      // Constant-index lookup keeps the select legal for any NUM_REQ
      cand_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cand == ID_W'(i)) begin
          cand_valid = req_valid[i];
        end
      end
      if (!found && cand_valid) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Operand mux for the winning requester
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_a = req_a[i*WIDTH +: WIDTH];
        win_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves one past the winner so the winner has lowest priority next
  always_comb begin
    if (winner == ID_W'(NUM_REQ-1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = winner + 1'b1;
    end
  end

  // One-hot accept only in IDLE and only out of reset
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && found) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (winner == ID_W'(i)) begin
          req_ready[i] = 1'b1;
        end
      end
    end
  end

  // Operand registers feed the comparator directly; they only change on an
  // accept, so the comparator inputs hold their last value outside COMPARE.
  assign cmp_a     = op_a;
  assign cmp_b     = op_b;
  assign dbg_state = state;

  // Main FSM: accept, compare, hold response until consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_id      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_equal   <= 1'b0;
      rsp_greater <= 1'b0;
      rsp_less    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= win_a;
            op_b   <= win_b;
            gnt_id <= winner;
            rr_ptr <= next_ptr;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          // Comparator flags are forwarded untouched, even if not one-hot
          rsp_equal   <= cmp_equal;
          rsp_greater <= cmp_greater;
          rsp_less    <= cmp_less;
          rsp_id      <= gnt_id;
          rsp_valid   <= 1'b1;
          state       <= RESPOND;
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMP_RESULT_CHECK_EN
  logic loc_eq;
  logic loc_gt;
  logic loc_lt;
  logic res_onehot;
  logic chk_bad;

  // Local unsigned reference compare of the registered operands
  always_comb begin
    loc_eq     = (op_a == op_b);
    loc_gt     = (op_a >  op_b);
    loc_lt     = (op_a <  op_b);
    res_onehot = ({cmp_equal, cmp_greater, cmp_less} == 3'b100) ||
                 ({cmp_equal, cmp_greater, cmp_less} == 3'b010) ||
                 ({cmp_equal, cmp_greater, cmp_less} == 3'b001);
    chk_bad    = (loc_eq != cmp_equal) || (loc_gt != cmp_greater) ||
                 (loc_lt != cmp_less) || !res_onehot;
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_err <= 1'b0;
    end else if ((state == COMPARE) && chk_bad) begin
      cmp_err <= 1'b1;
    end
  end
`else
  assign cmp_err = 1'b0;
`endif

endmodule
